// File: rtl/pose_sequencer_pkg.sv
// Shared pose codes and helpers for the pose sequencer and its debouncers.
package pose_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        POSE_0 = 2'd0,
        POSE_1 = 2'd1,
        POSE_2 = 2'd2
    } pose_t;

    localparam pose_t POSE_LAST = POSE_2;

    function automatic pose_t next_pose(input pose_t p);
        pose_t n;
        case (p)
            POSE_0:    n = POSE_1;
            POSE_1:    n = POSE_2;
            POSE_LAST: n = POSE_0;
            default:   n = POSE_0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pose_sequencer_btn_debounce.sv
// Two-flop synchronizer, consecutive-cycle debouncer and rising-edge press pulse
// for one raw push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic div_clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Synchronize, count consecutive mismatches, flip level and pulse on a 0->1 flip.
    always_ff @(posedge div_clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/pose_sequencer.sv
// Cycles the display pose 0->1->2->0, either on a hold timer (auto mode) or on
// debounced next-button presses (manual mode); the mode button toggles between them.
module pose_sequencer
    import pose_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 500
) (
    input  logic               div_clk,
    input  logic               reset,
    input  logic               btn_next,
    input  logic               btn_mode,
    output logic [STATE_W-1:0] state,
    output logic               auto_mode,
    output logic               advance
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic              w_next_press;
    logic              w_mode_press;
    pose_t             r_state;
    logic              r_auto;
    logic              r_adv;
    logic [HOLD_W-1:0] r_hold;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .div_clk (div_clk),
        .reset   (reset),
        .i_btn   (btn_next),
        .o_press (w_next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .div_clk (div_clk),
        .reset   (reset),
        .i_btn   (btn_mode),
        .o_press (w_mode_press)
    );

    // Pose FSM: a next press always wins over the hold timer so a coincident
    // terminal count still yields a single advance.
    always_ff @(posedge div_clk) begin
        if (!reset) begin
            r_state <= POSE_0;
            r_auto  <= 1'b1;
            r_adv   <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_adv <= 1'b0;
            if (w_mode_press) begin
                r_auto <= ~r_auto;
                r_hold <= '0;
                if (w_next_press) begin
                    r_state <= next_pose(r_state);
                    r_adv   <= 1'b1;
                end else begin
                    r_state <= r_state;
                end
            end else if (w_next_press) begin
                r_state <= next_pose(r_state);
                r_adv   <= 1'b1;
                r_hold  <= '0;
            end else if (r_auto && (r_hold == HOLD_LAST)) begin
                r_state <= next_pose(r_state);
                r_adv   <= 1'b1;
                r_hold  <= '0;
            end else if (r_auto) begin
                r_hold <= r_hold + HOLD_ONE;
            end else begin
                r_hold <= '0;
            end
        end
    end

    assign state     = r_state;
    assign auto_mode = r_auto;
    assign advance   = r_adv;

endmodule

// File: tb/tb_pose_sequencer.sv
// Randomized and directed bench for pose_sequencer against a window-based
// behavioural model of the buttons and a cycle-count model of the poses.
module tb_pose_sequencer;

    localparam int D = 4;
    localparam int H = 8;

    logic       div_clk  = 1'b0;
    logic       reset    = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_mode = 1'b0;
    logic [1:0] state;
    logic       auto_mode;
    logic       advance;

    int n_vec = 0;
    int n_err = 0;

    pose_sequencer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .div_clk   (div_clk),
        .reset     (reset),
        .btn_next  (btn_next),
        .btn_mode  (btn_mode),
        .state     (state),
        .auto_mode (auto_mode),
        .advance   (advance)
    );

    always #5 div_clk = ~div_clk;

    // Model: a level flips once the last D synchronized samples all disagree with it.
    bit           m_s1 [2];
    bit           m_s2 [2];
    bit           m_lvl[2];
    bit           m_prs[2];
    logic [D-1:0] m_win[2];
    int           m_state   = 0;
    int           m_elapsed = 0;
    bit           m_auto    = 1'b1;
    bit           m_adv     = 1'b0;
    bit           m_rst_edge = 1'b1;
    bit           mon_en    = 1'b0;
    logic [1:0]   mon_prev  = 2'd0;

    task automatic step();
        bit raw[2];
        bit r;
        bit pn;
        bit pm;
        raw[0] = btn_next;
        raw[1] = btn_mode;
        r      = reset;
        @(posedge div_clk);
        if (!r) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0; m_prs[b] = 1'b0;
                m_win[b] = '0;
            end
            m_state = 0; m_auto = 1'b1; m_elapsed = 0; m_adv = 1'b0;
        end else begin
            pn = m_prs[0];
            pm = m_prs[1];
            m_adv = 1'b0;
            if (pm) begin
                m_auto = !m_auto;
                m_elapsed = 0;
            end
            if (pn) begin
                m_state = (m_state + 1) % 3; m_adv = 1'b1; m_elapsed = 0;
            end else if (!pm) begin
                if (m_auto) begin
                    m_elapsed++;
                    if (m_elapsed == H) begin
                        m_state = (m_state + 1) % 3; m_adv = 1'b1; m_elapsed = 0;
                    end
                end else begin
                    m_elapsed = 0;
                end
            end
            for (int b = 0; b < 2; b++) begin
                m_win[b] = {m_win[b][D-2:0], m_s2[b]};
                m_s2[b]  = m_s1[b];
                m_s1[b]  = raw[b];
                m_prs[b] = 1'b0;
                if (m_win[b] == {D{~m_lvl[b]}}) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_prs[b] = m_lvl[b];
                end
            end
        end
        m_rst_edge = !r;
        @(negedge div_clk);
    endtask

    // Every-cycle scoreboard plus the pose/advance invariants.
    always @(negedge div_clk) begin
        if (mon_en) begin
            n_vec++;
            if (state !== m_state[1:0]) begin
                n_err++; $display("FAIL mon_state: got %0d exp %0d at %0t", state, m_state, $time);
            end
            n_vec++;
            if (auto_mode !== m_auto) begin
                n_err++; $display("FAIL mon_auto: got %0b exp %0b at %0t", auto_mode, m_auto, $time);
            end
            n_vec++;
            if (advance !== m_adv) begin
                n_err++; $display("FAIL mon_advance: got %0b exp %0b at %0t", advance, m_adv, $time);
            end
            n_vec++;
            if (state === 2'd3) begin
                n_err++; $display("FAIL inv_state3: got %0d exp not 3 at %0t", state, $time);
            end
            if (!m_rst_edge) begin
                n_vec++;
                if (advance !== (state != mon_prev)) begin
                    n_err++;
                    $display("FAIL inv_advance: got %0b exp %0b at %0t", advance, (state != mon_prev), $time);
                end
            end
            mon_prev = state;
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) step();
        mon_en = 1'b1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int advs;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            mon_en = 1'b1;
            n_vec++;
            if (state !== 2'd0 || auto_mode !== 1'b1 || advance !== 1'b0) begin
                n_err++;
                $display("FAIL reset_vals: got s=%0d a=%0b adv=%0b exp s=0 a=1 adv=0", state, auto_mode, advance);
            end
        end
        reset = 1'b1;
        advs = 0;
        for (int e = 1; e <= 24; e++) begin
            step();
            if (advance === 1'b1) advs++;
            if (e % H == 0) begin
                n_vec++;
                if (state !== 2'((e / H) % 3) || advance !== 1'b1) begin
                    n_err++;
                    $display("FAIL auto_step%0d: got s=%0d adv=%0b exp s=%0d adv=1", e, state, advance, (e / H) % 3);
                end
            end
        end
        n_vec++;
        if (advs != 3) begin
            n_err++; $display("FAIL auto_count: got %0d exp 3", advs);
        end
    endtask

    task automatic test_manual();
        int advs;
        do_reset(2);
        btn_mode = 1'b1; repeat (8) step();
        btn_mode = 1'b0; repeat (8) step();
        n_vec++;
        if (auto_mode !== 1'b0 || state !== 2'd0) begin
            n_err++; $display("FAIL manual_enter: got a=%0b s=%0d exp a=0 s=0", auto_mode, state);
        end
        for (int k = 0; k < 3; k++) begin
            btn_next = 1'b1; repeat (8) step();
            btn_next = 1'b0; repeat (8) step();
            n_vec++;
            if (state !== 2'((k + 1) % 3)) begin
                n_err++; $display("FAIL manual_press%0d: got %0d exp %0d", k, state, (k + 1) % 3);
            end
        end
        advs = 0;
        repeat (40) begin
            step();
            if (advance === 1'b1) advs++;
        end
        n_vec++;
        if (advs != 0) begin
            n_err++; $display("FAIL manual_idle: got %0d advances exp 0", advs);
        end
    endtask

    task automatic test_bounce();
        int advs;
        int idx;
        bit pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        advs = 0;
        idx  = -1;
        for (int i = 0; i < 4; i++) begin
            btn_next = pat[i]; step();
            if (advance === 1'b1) advs++;
        end
        btn_next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (advance === 1'b1) begin advs++; idx = i; end
        end
        btn_next = 1'b0;
        repeat (10) begin
            step();
            if (advance === 1'b1) advs++;
        end
        n_vec++;
        if (advs != 1) begin
            n_err++; $display("FAIL bounce_count: got %0d exp 1", advs);
        end
        n_vec++;
        if (idx < 2 + D - 1 || idx > 2 + D + 1) begin
            n_err++; $display("FAIL bounce_latency: got %0d exp %0d+/-1", idx, 2 + D);
        end
        n_vec++;
        if (state !== 2'd1) begin
            n_err++; $display("FAIL bounce_state: got %0d exp 1", state);
        end
    endtask

    task automatic test_coincide();
        int advs;
        do_reset(2);
        advs = 0;
        for (int e = 1; e <= 16; e++) begin
            btn_next = (e >= 2 && e < 8);
            step();
            if (e < 16 && advance === 1'b1) advs++;
            if (e == 8 || e == 16) begin
                n_vec++;
                if (state !== 2'(e / H) || advance !== 1'b1) begin
                    n_err++;
                    $display("FAIL coincide_e%0d: got s=%0d adv=%0b exp s=%0d adv=1", e, state, advance, e / H);
                end
            end
        end
        btn_next = 1'b0;
        n_vec++;
        if (advs != 1) begin
            n_err++; $display("FAIL coincide_count: got %0d exp 1", advs);
        end
    endtask

    task automatic test_held_reset();
        int advs;
        btn_next = 1'b1;
        do_reset(3);
        advs = 0;
        for (int e = 1; e <= 15; e++) begin
            step();
            if (e < 15 && advance === 1'b1) advs++;
            if (e == 7 || e == 15) begin
                n_vec++;
                if (state !== 2'((e == 7) ? 1 : 2) || advance !== 1'b1) begin
                    n_err++;
                    $display("FAIL held_e%0d: got s=%0d adv=%0b exp adv=1", e, state, advance);
                end
            end
        end
        btn_next = 1'b0;
        repeat (8) step();
        n_vec++;
        if (advs != 1) begin
            n_err++; $display("FAIL held_count: got %0d exp 1", advs);
        end
    endtask

    task automatic test_reset_mid();
        int advs;
        do_reset(2);
        for (int e = 1; e <= 21; e++) begin
            btn_mode = (e >= 19);
            step();
        end
        btn_mode = 1'b0;
        n_vec++;
        if (state !== 2'd2) begin
            n_err++; $display("FAIL mid_setup: got %0d exp 2", state);
        end
        do_reset(2);
        n_vec++;
        if (state !== 2'd0 || auto_mode !== 1'b1) begin
            n_err++; $display("FAIL mid_reset: got s=%0d a=%0b exp s=0 a=1", state, auto_mode);
        end
        advs = 0;
        for (int e = 1; e <= H; e++) begin
            step();
            if (e < H && advance === 1'b1) advs++;
        end
        n_vec++;
        if (advs != 0 || advance !== 1'b1 || state !== 2'd1) begin
            n_err++;
            $display("FAIL mid_restart: got early=%0d adv=%0b s=%0d exp early=0 adv=1 s=1", advs, advance, state);
        end
    endtask

    task automatic test_random();
        int run;
        for (int i = 0; i < 120; i++) begin
            btn_next = $urandom_range(0, 1);
            btn_mode = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 40) != 0);
            run      = $urandom_range(1, 10);
            repeat (run) step();
            reset = 1'b1;
        end
        btn_next = 1'b0;
        btn_mode = 1'b0;
        repeat (20) step();
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bounce();
        test_coincide();
        test_held_reset();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pose_sequencer.md
POSE_SEQUENCER -- requirements
Module: pose_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable div_clk cycles required before a button level is accepted.
REQ-002 Parameter HOLD_CYCLES, default 500: div_clk cycles each pose is held in auto mode.
REQ-003 div_clk  input  1  scan-rate clock, shared with the dot-matrix display stage; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-low; sampled on posedge div_clk.
REQ-005 btn_next  input  1  raw asynchronous push-button, active-high; requests the next pose.
REQ-006 btn_mode  input  1  raw asynchronous push-button, active-high; toggles auto/manual mode.
REQ-007 state  output  2  pose code driven to the display stage: 0, 1 or 2; the value 3 is never driven.
REQ-008 auto_mode  output  1  1 = auto-advance, 0 = manual.
REQ-009 advance  output  1  one-cycle pulse, high in the cycle in which state takes a new value.

Function
REQ-010 Each button passes through a two-flop synchronizer, then a debouncer.
REQ-011 The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the count.
REQ-012 A debounced 0->1 transition produces a one-cycle press pulse; holding the button produces no further pulses; release produces none.
REQ-013 Latency: a raw press stable from cycle N yields a press pulse at N+2+DEBOUNCE_CYCLES (+/-1 for async sampling).
REQ-014 Pose sequence is 0->1->2->0, with wrap from 2 to 0.
REQ-015 Auto mode: hold counter increments every cycle; at HOLD_CYCLES-1 it clears and state advances on the same edge.
REQ-016 Manual mode: hold counter is held at 0; state advances only on a next-press pulse.
REQ-017 Auto mode, next-press pulse: state advances immediately and the hold counter clears, restarting the full hold period.
REQ-018 Next-press pulse in the same cycle as hold-counter terminal count: exactly one advance.
REQ-019 Mode-press pulse toggles auto_mode on the next edge and clears the hold counter; state is unchanged.
REQ-020 Simultaneous mode-press and next-press pulses: mode toggles and state advances once.
REQ-021 state and auto_mode are registered outputs; a press pulse in cycle K is visible on state at cycle K+1.
REQ-022 advance is asserted exactly in the cycles where state differs from its previous value.

Reset
REQ-023 While reset=0 at a clock edge: state=0, auto_mode=1, advance=0, hold counter=0, debounce counters=0, debounced levels=0, synchronizer flops=0.
REQ-024 A button held through reset deassertion is accepted only after a full debounce period and then yields a single press pulse.
REQ-025 Reset asserted mid-hold or mid-debounce discards all progress; there is no partial carry-over.

Structure
REQ-026 Shared package holds the pose codes (POSE_0=0, POSE_1=1, POSE_2=2), POSE_LAST=2 and the state width (2).
REQ-027 One sub-module, btn_debounce (synchronizer + debouncer + rising-edge pulse, parameterized by DEBOUNCE_CYCLES), is instantiated twice.
REQ-028 Counter widths are derived from the parameters via clog2; no hard-coded widths.

Verification (bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-029 Reset low for 3 cycles, then released with buttons idle -> state=0 and auto_mode=1; state becomes 1 after 8 cycles, 2 after 16, and 0 after 24, with advance pulsed each time.
REQ-030 Bounce btn_next 1,0,1,0 on alternating cycles, then hold it high for 10 cycles -> exactly one advance, at 2+4 cycles after the stable high begins (+/-1).
REQ-031 Press btn_mode, then press btn_next three times in manual mode -> auto_mode=0; state steps 0->1->2->0; no advance occurs in 40 idle cycles.
REQ-032 In auto mode, press btn_next so its pulse coincides with hold-count 7 -> state advances by exactly one and the next auto advance follows 8 cycles later.
REQ-033 Assert reset at hold-count 5 with state=2 -> state=0, and the next advance occurs a full 8 cycles after reset is released.
REQ-034 Over all scenarios, a bench assertion checks state != 3 and advance == (state != previous state) on every cycle.
